mux2x1_stream_arbiter: RTL and testbench

// - Merges two valid/ready input streams (I1, I2) onto one output stream (M); inverse of the demux1x2 fan-out.
// - Round-robin arbitration between the inputs, feeding a single registered output stage.
// - Full throughput of one beat per cycle.
// - Sits wherever two producers share one consumer, e.g. upstream of a demux1x2 link.
//

---
 rtl/mux2x1_stream_arbiter.sv | 139 +++++++++++++
 tb/tb_mux2x1_stream_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mux2x1_stream_arbiter.sv
// Two-input valid/ready merge with round-robin arbitration into a one-entry registered output stage.
// Define MUX2X1_PACKET_LOCK_EN to hold the grant on one input from its first beat to its LAST beat.
module mux2x1_stream_arbiter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [W-1:0] i1_data_i,
  input  logic         i1_valid_i,
  input  logic         i1_last_i,
  output logic         i1_ready_o,
  input  logic [W-1:0] i2_data_i,
  input  logic         i2_valid_i,
  input  logic         i2_last_i,
  output logic         i2_ready_o,
  output logic [W-1:0] m_data_o,
  output logic         m_valid_o,
  output logic         m_sel_o,
  output logic         m_last_o,
  input  logic         m_ready_i
);

  logic [W-1:0] m_data_q, m_data_d;
  logic         m_valid_q, m_valid_d;
  logic         m_sel_q, m_sel_d;
  logic         last_gnt_q, last_gnt_d;  // 1 = I2 was granted last
  logic         load_ok;
  logic         gnt1, gnt2;
  logic         acc1, acc2;

`ifdef MUX2X1_PACKET_LOCK_EN
  typedef enum logic [1:0] {ARB, LOCK1, LOCK2} lock_e;
  lock_e lock_q, lock_d;
  logic  m_last_q, m_last_d;
`endif

  assign load_ok = ~m_valid_q | m_ready_i;

  always_comb begin
    gnt1 = 1'b0;
    gnt2 = 1'b0;
    if (i1_valid_i && i2_valid_i) begin
      gnt1 = last_gnt_q;
      gnt2 = ~last_gnt_q;
    end else begin
      gnt1 = i1_valid_i;
      gnt2 = i2_valid_i;
    end
`ifdef MUX2X1_PACKET_LOCK_EN
    if (lock_q == LOCK1) begin
      gnt1 = 1'b1;
      gnt2 = 1'b0;
    end else if (lock_q == LOCK2) begin
      gnt1 = 1'b0;
      gnt2 = 1'b1;
    end
`endif
  end

  assign i1_ready_o = en_i & load_ok & gnt1;
  assign i2_ready_o = en_i & load_ok & gnt2;
  assign acc1       = i1_valid_i & i1_ready_o;
  assign acc2       = i2_valid_i & i2_ready_o;

  always_comb begin
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    m_sel_d    = m_sel_q;
    last_gnt_d = last_gnt_q;
    if (acc1) begin
      m_data_d   = i1_data_i;
      m_valid_d  = 1'b1;
      m_sel_d    = 1'b0;
      last_gnt_d = 1'b0;
    end else if (acc2) begin
      m_data_d   = i2_data_i;
      m_valid_d  = 1'b1;
      m_sel_d    = 1'b1;
      last_gnt_d = 1'b1;
    end else if (m_ready_i) begin
      m_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_sel_q    <= 1'b0;
      last_gnt_q <= 1'b1;
    end else begin
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_sel_q    <= m_sel_d;
      last_gnt_q <= last_gnt_d;
    end
  end

`ifdef MUX2X1_PACKET_LOCK_EN
  always_comb begin
    lock_d   = lock_q;
    m_last_d = m_last_q;
    if (acc1) m_last_d = i1_last_i;
    else if (acc2) m_last_d = i2_last_i;
    unique case (lock_q)
      ARB: begin
        if (acc1 && !i1_last_i) lock_d = LOCK1;
        else if (acc2 && !i2_last_i) lock_d = LOCK2;
      end
      LOCK1: if (acc1 && i1_last_i) lock_d = ARB;
      LOCK2: if (acc2 && i2_last_i) lock_d = ARB;
      default: lock_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q   <= ARB;
      m_last_q <= 1'b0;
    end else begin
      lock_q   <= lock_d;
      m_last_q <= m_last_d;
    end
  end

  assign m_last_o = m_last_q;
`else
  // LAST inputs have no effect in per-beat round-robin mode.
  logic unused_last;
  assign unused_last = i1_last_i ^ i2_last_i;
  assign m_last_o    = 1'b0;
`endif

  assign m_data_o  = m_data_q;
  assign m_valid_o = m_valid_q;
  assign m_sel_o   = m_sel_q;

endmodule

// File: tb/tb_mux2x1_stream_arbiter.sv
// Directed bench for mux2x1_stream_arbiter: reference model of grant/ready plus a beat scoreboard.
// Honours MUX2X1_PACKET_LOCK_EN so the same stimulus checks either build.
module tb_mux2x1_stream_arbiter;

`ifdef MUX2X1_PACKET_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] i1_data = 8'h00, i2_data = 8'h00;
  logic       i1_valid = 1'b0, i2_valid = 1'b0;
  logic       i1_last = 1'b1, i2_last = 1'b1;
  logic       i1_ready, i2_ready;
  logic [7:0] m_data;
  logic       m_valid, m_sel, m_last;
  logic       m_ready = 1'b0;

  mux2x1_stream_arbiter #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en),
    .i1_data_i(i1_data), .i1_valid_i(i1_valid), .i1_last_i(i1_last), .i1_ready_o(i1_ready),
    .i2_data_i(i2_data), .i2_valid_i(i2_valid), .i2_last_i(i2_last), .i2_ready_o(i2_ready),
    .m_data_o(m_data), .m_valid_o(m_valid), .m_sel_o(m_sel), .m_last_o(m_last),
    .m_ready_i(m_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  bit         mv, msel, mlast, lastg;
  logic [7:0] mdata;
  int         lock;
  logic [9:0] sb[$];
  int         i2_cnt = 0;
  bit         pkt_mode = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mv = 0; mdata = 8'h00; msel = 0; mlast = 0; lastg = 1; lock = 0;
    sb.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_m_sel"}, m_sel, 0);
    chk({tag, "_m_last"}, m_last, 0);
  endtask

  task automatic cycle();
    bit lok, g1, g2, r1, r2, a1, a2;
    logic [9:0] e;
    @(negedge clk);
    lok = !mv || (m_ready === 1'b1);
    if (i1_valid && i2_valid) begin
      g1 = lastg; g2 = !lastg;
    end else begin
      g1 = i1_valid; g2 = i2_valid;
    end
    if (LOCK_EN && lock == 1) begin g1 = 1; g2 = 0; end
    if (LOCK_EN && lock == 2) begin g1 = 0; g2 = 1; end
    r1 = en && lok && g1;
    r2 = en && lok && g2;
    chk("i1_ready", i1_ready, r1);
    chk("i2_ready", i2_ready, r2);
    chk("m_valid", m_valid, mv);
    if (mv) begin
      chk("m_data", m_data, mdata);
      chk("m_sel", m_sel, msel);
      chk("m_last", m_last, mlast);
    end
    if (m_valid === 1'b1 && m_ready) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_beat", {m_last, m_sel, m_data}, e);
        $display("beat sel=%0d last=%0d data=%02h", m_sel, m_last, m_data);
      end
    end
    a1 = i1_valid && r1;
    a2 = i2_valid && r2;
    if (a1) begin
      mv = 1; mdata = i1_data; msel = 0; lastg = 0;
      mlast = LOCK_EN ? i1_last : 1'b0;
      sb.push_back({mlast, 1'b0, i1_data});
      if (LOCK_EN && lock == 0 && !i1_last) lock = 1;
      else if (lock == 1 && i1_last) lock = 0;
    end else if (a2) begin
      mv = 1; mdata = i2_data; msel = 1; lastg = 1;
      mlast = LOCK_EN ? i2_last : 1'b0;
      sb.push_back({mlast, 1'b1, i2_data});
      if (LOCK_EN && lock == 0 && !i2_last) lock = 2;
      else if (lock == 2 && i2_last) lock = 0;
    end else if (m_ready) begin
      mv = 0;
    end
    @(posedge clk);
    #1;
    if (a1) i1_data = i1_data + 8'd1;
    if (a2) begin
      i2_data = i2_data + 8'd1;
      i2_cnt++;
      i2_last = !pkt_mode || (i2_cnt % 3 == 2);
    end
  endtask

  initial begin
    model_reset();
    #3;
    chk_reset_outputs("rst_init");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single source
    en = 1; m_ready = 1; i1_data = 8'hA5; i1_valid = 1;
    cycle();
    i1_valid = 0;
    cycle();

    // Async reset while a beat is held
    i1_data = 8'h3C; i1_valid = 1; m_ready = 0;
    cycle();
    i1_valid = 0;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("rst_async");
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Contention, I1 first after reset
    i1_data = 8'h10; i2_data = 8'h80; i1_valid = 1; i2_valid = 1; m_ready = 1;
    repeat (8) cycle();

    // Backpressure
    m_ready = 0;
    repeat (3) cycle();
    m_ready = 1;
    repeat (4) cycle();

    // Enable low with a held beat
    m_ready = 0;
    cycle();
    en = 0;
    cycle();
    m_ready = 1;
    repeat (3) cycle();
    en = 1;
    repeat (2) cycle();

    // Packet from I2 (3 beats, LAST on the third) while I1 stays valid
    i1_valid = 0; i2_valid = 0;
    repeat (2) cycle();
    pkt_mode = 1; i2_cnt = 0; i2_last = 0;
    i1_valid = 1; i2_valid = 1;
    repeat (8) cycle();
    pkt_mode = 0; i2_last = 1;

    // Drain
    i1_valid = 0; i2_valid = 0; m_ready = 1;
    repeat (3) cycle();
    chk("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
